// File: rtl/serial_pkg.sv
// serial_pkg: constants, FSM state type and parity helper shared by the serial
// transmitter and receiver.
package serial_pkg;

    localparam int unsigned DATA_WIDTH = 8;

    // Line states: IDLE (nothing on the line), DATA (bit counter selects the bit),
    // PARITY (trailing parity bit, only reachable when parity is built in).
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } p2s_state_e;

    // Even-style parity: XOR of all data bits.
    function automatic logic xor_parity(input logic [DATA_WIDTH-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/parallel_to_serial.sv
// parallel_to_serial: accepts bytes over a valid/ready handshake and shifts them out
// LSB first, one bit per cycle, with a start_bit marker on bit 0. A one-entry holding
// buffer lets the next byte follow the current frame with no idle cycles.
// Build option: P2S_PARITY_EN adds an optional per-byte parity bit (XOR of data bits);
// without it parity_enable is ignored and every frame is 8 bits.
module parallel_to_serial
    import serial_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    input  logic                  parity_enable,
    output logic                  start_bit,
    output logic                  serial_data,
    output logic                  busy
);

    localparam int unsigned      CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    p2s_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  buf_full_q, buf_full_d;
    logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
    logic                  start_q, start_d;
    logic                  serial_q, serial_d;
    logic                  busy_q, busy_d;
    logic                  accept;
    logic                  frame_end;

`ifdef P2S_PARITY_EN
    logic par_q, par_d;
    logic buf_par_q, buf_par_d;
`else
    logic unused_parity_enable;
    assign unused_parity_enable = parity_enable;
`endif

    // Ready depends only on buffer occupancy, never on the line state.
    assign data_in_ready = ~buf_full_q;
    assign start_bit     = start_q;
    assign serial_data   = serial_q;
    assign busy          = busy_q;

    // Next-state: decide what goes on the line next cycle and manage the buffer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        buf_full_d = buf_full_q;
        buf_data_d = buf_data_q;
        start_d    = 1'b0;
        serial_d   = 1'b0;
`ifdef P2S_PARITY_EN
        par_d      = par_q;
        buf_par_d  = buf_par_q;
`endif

        accept = data_in_valid & ~buf_full_q;

        // frame_end: the line is free for a new frame after this edge.
        frame_end = 1'b1;
        if (state_q == DATA) begin
            frame_end = (cnt_q == LAST_BIT);
`ifdef P2S_PARITY_EN
            if (par_q) begin
                frame_end = 1'b0;
            end
`endif
        end

        if (frame_end) begin
            if (buf_full_q) begin
                // Buffered byte has priority; ready is low so nothing new arrives now.
                state_d    = DATA;
                cnt_d      = '0;
                data_d     = buf_data_q;
                buf_full_d = 1'b0;
                start_d    = 1'b1;
                serial_d   = buf_data_q[0];
`ifdef P2S_PARITY_EN
                par_d      = buf_par_q;
`endif
            end else if (accept) begin
                // Bypass the buffer so bit 0 appears right after the accepting edge.
                state_d  = DATA;
                cnt_d    = '0;
                data_d   = data_in;
                start_d  = 1'b1;
                serial_d = data_in[0];
`ifdef P2S_PARITY_EN
                par_d    = parity_enable;
`endif
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end else begin
            if (accept) begin
                buf_full_d = 1'b1;
                buf_data_d = data_in;
`ifdef P2S_PARITY_EN
                buf_par_d  = parity_enable;
`endif
            end
            if (cnt_q != LAST_BIT) begin
                cnt_d    = cnt_q + 1'b1;
                serial_d = data_q[cnt_d];
            end
`ifdef P2S_PARITY_EN
            else begin
                state_d  = PARITY;
                serial_d = xor_parity(data_q);
            end
`endif
        end

        busy_d = (state_d != IDLE) | buf_full_d;
    end

    // State, buffer and registered line outputs; reset aborts any frame at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            buf_full_q <= 1'b0;
            buf_data_q <= '0;
            start_q    <= 1'b0;
            serial_q   <= 1'b0;
            busy_q     <= 1'b0;
`ifdef P2S_PARITY_EN
            par_q      <= 1'b0;
            buf_par_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            buf_full_q <= buf_full_d;
            buf_data_q <= buf_data_d;
            start_q    <= start_d;
            serial_q   <= serial_d;
            busy_q     <= busy_d;
`ifdef P2S_PARITY_EN
            par_q      <= par_d;
            buf_par_q  <= buf_par_d;
`endif
        end
    end

endmodule

// File: tb/tb_parallel_to_serial.sv
// tb_parallel_to_serial: randomized and directed stimulus against a queue-based line
// model plus a behavioural receiver that reassembles bytes from the serial line.
module tb_parallel_to_serial;

`ifdef P2S_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    typedef struct packed {
        logic st;
        logic b;
    } line_bit_t;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
    } sent_t;

    logic       clock;
    logic       reset_n;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;
    logic       parity_enable;
    logic       start_bit;
    logic       serial_data;
    logic       busy;

    parallel_to_serial dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .parity_enable (parity_enable),
        .start_bit     (start_bit),
        .serial_data   (serial_data),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: every accepted byte appends its whole frame to line_q; one
    // entry leaves per clock edge and is what the line must show after that edge.
    line_bit_t line_q[$];
    sent_t     sent_q[$];
    int        pending;
    int        n_acc;
    logic      exp_start, exp_ser, exp_busy, exp_ready;

    // Receiver state.
    int         rx_cnt;
    logic [7:0] rx_byte;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        line_q.delete();
        sent_q.delete();
        pending   = 0;
        exp_start = 1'b0;
        exp_ser   = 1'b0;
        exp_busy  = 1'b0;
        exp_ready = 1'b1;
        rx_cnt    = 0;
        rx_byte   = '0;
    endtask

    task automatic model_edge(input logic acc, input logic [7:0] d, input logic p);
        line_bit_t e;
        logic      eff;
        eff = p & PAR_BUILD;
        if (acc) begin
            for (int i = 0; i < 8; i++) begin
                e.st = (i == 0);
                e.b  = d[i];
                line_q.push_back(e);
            end
            if (eff) begin
                e.st = 1'b0;
                e.b  = ^d;
                line_q.push_back(e);
            end
            pending++;
            sent_q.push_back('{d: d, p: eff});
            n_acc++;
        end
        if (line_q.size() > 0) begin
            e         = line_q.pop_front();
            exp_start = e.st;
            exp_ser   = e.b;
            exp_busy  = 1'b1;
            if (e.st) pending--;
        end else begin
            exp_start = 1'b0;
            exp_ser   = 1'b0;
            exp_busy  = 1'b0;
        end
        exp_ready = (pending == 0);
    endtask

    // Behavioural receiver: rebuilds bytes from the line and checks them and parity.
    task automatic rx_sample();
        sent_t s;
        if (start_bit) begin
            rx_byte    = '0;
            rx_byte[0] = serial_data;
            rx_cnt     = 1;
        end else if (rx_cnt >= 1 && rx_cnt <= 7) begin
            rx_byte[rx_cnt] = serial_data;
            rx_cnt++;
            if (rx_cnt == 8) begin
                if (sent_q.size() == 0) begin
                    check_eq("rx_unexpected_byte", 32'd1, 32'd0);
                    rx_cnt = 0;
                end else begin
                    s = sent_q.pop_front();
                    check_eq("rx_byte", {24'd0, rx_byte}, {24'd0, s.d});
                    rx_cnt = s.p ? 8 : 0;
                end
            end
        end else if (rx_cnt == 8) begin
            check_eq("rx_parity_error", {31'd0, serial_data ^ (^rx_byte)}, 32'd0);
            rx_cnt = 0;
        end
    endtask

    task automatic check_outputs();
        check_eq("start_bit", {31'd0, start_bit}, {31'd0, exp_start});
        check_eq("serial_data", {31'd0, serial_data}, {31'd0, exp_ser});
        check_eq("busy", {31'd0, busy}, {31'd0, exp_busy});
        check_eq("data_in_ready", {31'd0, data_in_ready}, {31'd0, exp_ready});
        rx_sample();
    endtask

    // One clock cycle: check outputs, drive inputs, advance the model at the edge.
    task automatic step(input logic v, input logic [7:0] d, input logic p, output logic acc);
        @(negedge clock);
        check_outputs();
        data_in_valid = v;
        data_in       = v ? d : 8'($urandom);
        parity_enable = p;
        acc           = v & exp_ready;
        @(posedge clock);
        model_edge(acc, d, p);
    endtask

    task automatic idle(input int cycles);
        logic acc;
        for (int i = 0; i < cycles; i++) step(1'b0, 8'h00, 1'b0, acc);
    endtask

    // Offer bytes back to back, holding each until accepted (bounded).
    task automatic send_seq(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int count, input logic p);
        logic [7:0] bytes [3];
        logic       acc;
        int         idx;
        int         guard;
        bytes[0] = b0;
        bytes[1] = b1;
        bytes[2] = b2;
        idx      = 0;
        guard    = 0;
        while (idx < count && guard < 100) begin
            step(1'b1, bytes[idx], p, acc);
            if (acc) idx++;
            guard++;
        end
        check_eq("send_seq_accepted", idx, count);
    endtask

    task automatic async_reset();
        @(negedge clock);
        check_outputs();
        data_in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_start_bit", {31'd0, start_bit}, 32'd0);
        check_eq("rst_serial_data", {31'd0, serial_data}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_ready", {31'd0, data_in_ready}, 32'd1);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        model_edge(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        logic acc;
        int   guard;
        reset_n       = 1'b0;
        data_in       = '0;
        data_in_valid = 1'b0;
        parity_enable = 1'b0;
        n_acc         = 0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_outputs();
        reset_n = 1'b1;
        @(posedge clock);
        model_edge(1'b0, 8'h00, 1'b0);

        // Single idle send, then the line must return to 0 and busy drop.
        send_seq(8'hA5, 8'h00, 8'h00, 1, 1'b0);
        idle(11);

        // Parity frames: 0x07 has odd weight, 0x03 even.
        send_seq(8'h07, 8'h00, 8'h00, 1, 1'b1);
        idle(11);
        send_seq(8'h03, 8'h00, 8'h00, 1, 1'b1);
        idle(11);

        // Back-to-back pair, then a third byte that must wait for buffer space.
        send_seq(8'h3C, 8'hF0, 8'h00, 2, 1'b0);
        idle(20);
        send_seq(8'h11, 8'h22, 8'h33, 3, 1'b1);
        idle(30);

        // Reset at bit 4 of 0xFF with a byte buffered: nothing may resume afterwards.
        step(1'b1, 8'hFF, 1'b0, acc);
        step(1'b1, 8'h81, 1'b0, acc);
        idle(3);
        async_reset();
        idle(12);

        // Random traffic: 256 bytes with random validity and parity.
        n_acc = 0;
        guard = 0;
        while (n_acc < 256 && guard < 8000) begin
            step($urandom_range(0, 9) < 7, 8'($urandom), 1'($urandom), acc);
            guard++;
        end
        check_eq("random_bytes_accepted", n_acc, 256);
        idle(25);
        check_eq("rx_bytes_outstanding", sent_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
